// File: rtl/usbdev_pkg.sv
// usbdev_pkg
//   Shared types and constants for the usbdev always-on (AON) logic.
//   - aon_seq_state_e : state encoding of the AON suspend/wake sequencer
//   - WakeReason*     : bit positions inside the sticky wake-reason vector
package usbdev_pkg;

    // Sequencer states. Encodings 5..7 are unused and recover to IdleSt.
    typedef enum logic [2:0] {
        IdleSt    = 3'd0,
        ArmSt     = 3'd1,
        ActiveSt  = 3'd2,
        WakeSt    = 3'd3,
        ReleaseSt = 3'd4
    } aon_seq_state_e;

    // Bit positions in wake_reason_o.
    localparam int WakeReasonNotIdle   = 0;
    localparam int WakeReasonBusReset  = 1;
    localparam int WakeReasonSenseLost = 2;

endpackage : usbdev_pkg

// File: rtl/usbdev_aon_suspend_seq.sv
// usbdev_aon_suspend_seq
//   AON-domain sequencer between the synchronized usbdev register pulses and
//   the always-on wake detector. It turns the IP's suspend / wake-ack pulses
//   into the level handshake the detector expects, latches the wake reasons
//   reported while suspended, and raises a level wake event toward the power
//   manager.
//
// Parameters
//   ArmTimeout : max cycles to wait for detect_active_i=1 after a suspend request
//   RelTimeout : max cycles to wait for detect_active_i=0 after a wake ack
//
// Ports
//   clk_aon_i          in   AON clock
//   rst_aon_i          in   synchronous, active-high reset
//   suspend_req_i      in   1-cycle pulse: enter suspend
//   wake_ack_i         in   1-cycle pulse: software acks the wake / aborts
//   detect_active_i    in   detector active status
//   wake_req_i         in   detector wake request (level)
//   bus_not_idle_i     in   detector event: non-idle seen
//   bus_reset_i        in   detector event: bus reset seen
//   sense_lost_i       in   detector event: VBUS lost
//   suspend_req_aon_o  out  level suspend request to the detector
//   wake_ack_aon_o     out  level wake ack to the detector
//   wake_event_o       out  level wake request to the power manager
//   wake_reason_o      out  sticky reasons {sense_lost, bus_reset, not_idle}
//   state_o            out  current FSM state (debug)
//   err_timeout_o      out  1-cycle pulse on arm or release timeout
module usbdev_aon_suspend_seq
    import usbdev_pkg::*;
#(
    parameter int ArmTimeout = 16,
    parameter int RelTimeout = 16
) (
    input  logic       clk_aon_i,
    input  logic       rst_aon_i,
    input  logic       suspend_req_i,
    input  logic       wake_ack_i,
    input  logic       detect_active_i,
    input  logic       wake_req_i,
    input  logic       bus_not_idle_i,
    input  logic       bus_reset_i,
    input  logic       sense_lost_i,
    output logic       suspend_req_aon_o,
    output logic       wake_ack_aon_o,
    output logic       wake_event_o,
    output logic [2:0] wake_reason_o,
    output logic [2:0] state_o,
    output logic       err_timeout_o
);

    // One shared counter serves both timed states, so it is sized for the
    // larger of the two limits.
    localparam int CntMax = (ArmTimeout > RelTimeout) ? ArmTimeout : RelTimeout;
    localparam int CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] ArmLast = CntW'(ArmTimeout - 1);
    localparam logic [CntW-1:0] RelLast = CntW'(RelTimeout - 1);
    localparam logic [CntW-1:0] CntSat  = {CntW{1'b1}};

    aon_seq_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      reason_q, reason_d;
    logic            err_d;
    logic            suspend_d, wake_ack_d, wake_event_d;
    logic [2:0]      events;

    always_comb begin
        events                      = '0;
        events[WakeReasonNotIdle]   = bus_not_idle_i;
        events[WakeReasonBusReset]  = bus_reset_i;
        events[WakeReasonSenseLost] = sense_lost_i;
    end

    // Next-state / next-output logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        reason_d = reason_q;
        err_d    = 1'b0;

        case (state_q)
            IdleSt: begin
                // wake_ack_i is deliberately ignored here.
                if (suspend_req_i) begin
                    state_d  = ArmSt;
                    reason_d = '0;
                end
            end

            ArmSt: begin
                // An abort from software wins over both the detector and the timeout.
                if (wake_ack_i) begin
                    state_d = ReleaseSt;
                end else if (detect_active_i) begin
                    state_d = ActiveSt;
                end else if (cnt_q == ArmLast) begin
                    state_d = IdleSt;
                    err_d   = 1'b1;
                end
            end

            ActiveSt: begin
                reason_d = reason_q | events;
                // Ack beats a coincident wake request; reasons are still captured.
                if (wake_ack_i) begin
                    state_d = ReleaseSt;
                end else if (wake_req_i) begin
                    state_d = WakeSt;
                end
            end

            WakeSt: begin
                // No timeout: the wake stays asserted until software acks it.
                reason_d = reason_q | events;
                if (wake_ack_i) begin
                    state_d = ReleaseSt;
                end
            end

            ReleaseSt: begin
                if (!detect_active_i) begin
                    state_d = IdleSt;
                end else if (cnt_q == RelLast) begin
                    state_d = IdleSt;
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d = IdleSt;
            end
        endcase
    end

    // Cycle counter: restarts on every state change, counts only in the two
    // timed states and sticks at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ArmSt || state_q == ReleaseSt) && cnt_q != CntSat) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Outputs are decoded from the next state and registered, so each one
    // changes on the same edge as the state it belongs to.
    always_comb begin
        suspend_d    = (state_d == ArmSt) || (state_d == ActiveSt) || (state_d == WakeSt);
        wake_ack_d   = (state_d == ReleaseSt);
        wake_event_d = (state_d == WakeSt);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its inputs.
    always_ff @(posedge clk_aon_i) begin
        if (rst_aon_i) begin
            state_q           <= IdleSt;
            cnt_q             <= '0;
            reason_q          <= '0;
            suspend_req_aon_o <= 1'b0;
            wake_ack_aon_o    <= 1'b0;
            wake_event_o      <= 1'b0;
            err_timeout_o     <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            reason_q          <= reason_d;
            suspend_req_aon_o <= suspend_d;
            wake_ack_aon_o    <= wake_ack_d;
            wake_event_o      <= wake_event_d;
            err_timeout_o     <= err_d;
        end
    end

    assign wake_reason_o = reason_q;
    assign state_o       = state_q;

endmodule : usbdev_aon_suspend_seq

// File: tb/tb_usbdev_aon_suspend_seq.sv
// tb_usbdev_aon_suspend_seq
//   Directed bench for usbdev_aon_suspend_seq with default timeouts (16/16).
//   Inputs change 1 ns after a rising edge; outputs are checked at that
//   same point, i.e. just after the edge that produced them.
module tb_usbdev_aon_suspend_seq;

    localparam int ArmTimeout = 16;
    localparam int RelTimeout = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_ACT  = 3'd2;
    localparam logic [2:0] S_WAKE = 3'd3;
    localparam logic [2:0] S_REL  = 3'd4;

    logic       clk_aon_i = 1'b0;
    logic       rst_aon_i;
    logic       suspend_req_i, wake_ack_i, detect_active_i, wake_req_i;
    logic       bus_not_idle_i, bus_reset_i, sense_lost_i;
    logic       suspend_req_aon_o, wake_ack_aon_o, wake_event_o, err_timeout_o;
    logic [2:0] wake_reason_o, state_o;

    int n_assert = 0;
    int n_fail   = 0;

    usbdev_aon_suspend_seq #(
        .ArmTimeout(ArmTimeout),
        .RelTimeout(RelTimeout)
    ) dut (
        .clk_aon_i        (clk_aon_i),
        .rst_aon_i        (rst_aon_i),
        .suspend_req_i    (suspend_req_i),
        .wake_ack_i       (wake_ack_i),
        .detect_active_i  (detect_active_i),
        .wake_req_i       (wake_req_i),
        .bus_not_idle_i   (bus_not_idle_i),
        .bus_reset_i      (bus_reset_i),
        .sense_lost_i     (sense_lost_i),
        .suspend_req_aon_o(suspend_req_aon_o),
        .wake_ack_aon_o   (wake_ack_aon_o),
        .wake_event_o     (wake_event_o),
        .wake_reason_o    (wake_reason_o),
        .state_o          (state_o),
        .err_timeout_o    (err_timeout_o)
    );

    always #5 clk_aon_i = ~clk_aon_i;

    task automatic tick();
        @(posedge clk_aon_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks every output against one expected tuple.
    task automatic check_all(input string tag, input logic [2:0] st, input logic sus,
                             input logic ack, input logic wev, input logic [2:0] rsn,
                             input logic err);
        check({tag, ".state"},   8'(state_o),           8'(st));
        check({tag, ".sus_aon"}, 8'(suspend_req_aon_o), 8'(sus));
        check({tag, ".ack_aon"}, 8'(wake_ack_aon_o),    8'(ack));
        check({tag, ".wake_ev"}, 8'(wake_event_o),      8'(wev));
        check({tag, ".reason"},  8'(wake_reason_o),     8'(rsn));
        check({tag, ".err"},     8'(err_timeout_o),     8'(err));
    endtask

    initial begin
        rst_aon_i       = 1'b1;
        suspend_req_i   = 1'b0;
        wake_ack_i      = 1'b0;
        detect_active_i = 1'b0;
        wake_req_i      = 1'b0;
        bus_not_idle_i  = 1'b0;
        bus_reset_i     = 1'b0;
        sense_lost_i    = 1'b0;

        // Reset state.
        tick();
        tick();
        check_all("reset", S_IDLE, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        rst_aon_i = 1'b0;

        // Suspend handshake: detector goes active three cycles after the request.
        suspend_req_i = 1'b1;
        tick();
        suspend_req_i = 1'b0;
        check_all("arm0", S_ARM, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        check_all("arm1", S_ARM, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        check_all("arm2", S_ARM, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        detect_active_i = 1'b1;
        tick();
        check_all("active", S_ACT, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);

        // suspend_req_i in ACTIVE is ignored.
        suspend_req_i = 1'b1;
        tick();
        suspend_req_i = 1'b0;
        check_all("ign_act", S_ACT, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);

        // Wake on bus reset.
        bus_reset_i = 1'b1;
        wake_req_i  = 1'b1;
        tick();
        bus_reset_i = 1'b0;
        check_all("wake", S_WAKE, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0);

        // suspend_req_i in WAKE is ignored; WAKE holds without a timeout.
        suspend_req_i = 1'b1;
        tick();
        suspend_req_i = 1'b0;
        check_all("ign_wake", S_WAKE, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0);
        for (int i = 0; i < ArmTimeout + 4; i++) tick();
        check_all("wake_hold", S_WAKE, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0);

        // Software ack -> RELEASE; detector still active for one more cycle.
        wake_ack_i = 1'b1;
        tick();
        wake_ack_i = 1'b0;
        wake_req_i = 1'b0;
        check_all("rel0", S_REL, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0);
        tick();
        check_all("rel1", S_REL, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0);

        // Detector drops; a suspend_req_i on the same edge is dropped.
        detect_active_i = 1'b0;
        suspend_req_i   = 1'b1;
        tick();
        suspend_req_i = 1'b0;
        check_all("rel_done", S_IDLE, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);
        tick();
        check_all("drop_sus", S_IDLE, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);

        // wake_ack_i in IDLE changes nothing.
        wake_ack_i = 1'b1;
        tick();
        wake_ack_i = 1'b0;
        check_all("ign_idle_ack", S_IDLE, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);

        // Arm timeout: reasons clear on entering ARM, error after ArmTimeout cycles.
        suspend_req_i = 1'b1;
        tick();
        suspend_req_i = 1'b0;
        check_all("to_arm", S_ARM, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        for (int i = 1; i < ArmTimeout; i++) begin
            tick();
            check("to_wait.err",   8'(err_timeout_o), 8'd0);
            check("to_wait.state", 8'(state_o),       8'(S_ARM));
        end
        tick();
        check_all("to_fire", S_IDLE, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        tick();
        check_all("to_after", S_IDLE, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

        // Abort/wake collision in ACTIVE with VBUS lost.
        suspend_req_i = 1'b1;
        tick();
        suspend_req_i   = 1'b0;
        detect_active_i = 1'b1;
        tick();
        check_all("col_act", S_ACT, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        wake_ack_i   = 1'b1;
        wake_req_i   = 1'b1;
        sense_lost_i = 1'b1;
        tick();
        wake_ack_i   = 1'b0;
        wake_req_i   = 1'b0;
        sense_lost_i = 1'b0;
        check_all("collide", S_REL, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0);

        // Release timeout: detector never drops.
        for (int i = 1; i < RelTimeout; i++) begin
            tick();
            check("rto_wait.err",   8'(err_timeout_o), 8'd0);
            check("rto_wait.state", 8'(state_o),       8'(S_REL));
        end
        tick();
        check_all("rto_fire", S_IDLE, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1);

        // Reset mid-WAKE.
        suspend_req_i = 1'b1;
        tick();
        suspend_req_i = 1'b0;
        tick();
        bus_not_idle_i = 1'b1;
        wake_req_i     = 1'b1;
        tick();
        bus_not_idle_i = 1'b0;
        check_all("pre_rst", S_WAKE, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0);
        rst_aon_i = 1'b1;
        tick();
        rst_aon_i       = 1'b0;
        wake_req_i      = 1'b0;
        detect_active_i = 1'b0;
        check_all("mid_rst", S_IDLE, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        check_all("post_rst", S_IDLE, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_usbdev_aon_suspend_seq
